// File: rtl/apb_ttc_buffer_bridge.sv
// apb_ttc_buffer_bridge
// APB3 slave linking the MSS CPU to the TTC TX/RX packet buffers of NUM_CH
// channels. It provides a control/status register file with a maskable
// interrupt, byte-serial TX buffer windows and wait-stated RX buffer windows.
// Optional build macro: APB_TTC_PSLVERR_EN adds the PSLVERR error response.
module apb_ttc_buffer_bridge #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned BUF_AW    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter logic [31:0] VERSION   = 32'h0002_0000
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [31:0]           PADDR,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [31:0]           PWDATA,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic [NUM_CH-1:0]     tx_wen,
  output logic [BUF_AW+1:0]     tx_waddr,
  output logic [7:0]            tx_wdata,
  output logic [NUM_CH-1:0]     tx_start,
  input  logic [NUM_CH-1:0]     tx_done,
  output logic [NUM_CH-1:0]     rx_ren,
  output logic [BUF_AW-1:0]     rx_raddr,
  input  logic [32*NUM_CH-1:0]  rx_rdata,
  input  logic [NUM_CH-1:0]     rx_done,
`ifdef APB_TTC_PSLVERR_EN
  output logic                  PSLVERR,
`endif
  output logic                  irq
);

`ifdef APB_TTC_PSLVERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  // Window numbers: 0 = registers, 1..NUM_CH = TX, NUM_CH+1..2*NUM_CH = RX.
  localparam logic [18:0] TX_LAST = 19'(NUM_CH);
  localparam logic [18:0] RX_LAST = 19'(2 * NUM_CH);
  localparam logic [2:0]  NCH3    = 3'(NUM_CH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REG  = 3'd1,
    TXB  = 3'd2,
    RXW  = 3'd3,
    RXD  = 3'd4,
    ACK  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    T_CTRL = 3'd0,
    T_STAT = 3'd1,
    T_EN   = 3'd2,
    T_ID   = 3'd3,
    T_TX   = 3'd4,
    T_RX   = 3'd5,
    T_NONE = 3'd6
  } tgt_t;

  // One-hot channel strobe from a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [2:0] ch);
    logic [NUM_CH-1:0] oh;
    oh = {NUM_CH{1'b0}};
    for (int c = 0; c < NUM_CH; c++) begin
      oh[c] = (ch == 3'(c));
    end
    return oh;
  endfunction

  // Little-endian byte k of a word.
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  state_t               state_r;
  tgt_t                 tgt_r;
  logic [2:0]           chan_r;
  logic [31:0]          wdata_r;
  logic                 write_r;
  logic                 err_r;
  logic [1:0]           k_r;
  logic                 pready_r;
  logic [31:0]          prdata_r;
  logic [NUM_CH-1:0]    tx_wen_r;
  logic [BUF_AW+1:0]    tx_waddr_r;
  logic [7:0]           tx_wdata_r;
  logic [NUM_CH-1:0]    rx_ren_r;
  logic [BUF_AW-1:0]    rx_raddr_r;
  logic                 irq_r;

  logic [NUM_CH-1:0]    tx_start_r;
  logic [NUM_CH-1:0]    rx_ready_r;
  logic [NUM_CH-1:0]    rx_overrun_r;
  logic [NUM_CH-1:0]    tx_done_st_r;
  logic [NUM_CH-1:0]    rx_done_st_r;
  logic [NUM_CH-1:0]    en_tx_r;
  logic [NUM_CH-1:0]    en_rx_r;

  logic [31:0]          off_s;
  logic [18:0]          win_s;
  tgt_t                 tgt_s;
  logic [2:0]           ch_s;
  logic                 setup_s;
  logic [31:0]          rd_data_s;
  logic                 err_s;
  logic                 err_eff_s;
  logic [31:0]          rd_data_eff_s;
  logic [31:0]          rx_slice_s;
  logic                 commit_s;
  logic                 wr_ctrl_s;
  logic                 wr_stat_s;
  logic                 wr_en_s;

  // Address decode of the live setup phase into a target and channel.
  always_comb begin
    off_s   = PADDR - BASE_ADDR;
    win_s   = off_s[31:13];
    setup_s = PSEL & ~PENABLE;
    tgt_s   = T_NONE;
    ch_s    = 3'd0;
    if (win_s == 19'd0) begin
      if (off_s[12:4] == 9'd0) begin
        case (off_s[3:2])
          2'd0:    tgt_s = T_CTRL;
          2'd1:    tgt_s = T_STAT;
          2'd2:    tgt_s = T_EN;
          default: tgt_s = T_ID;
        endcase
      end else begin
        tgt_s = T_NONE;
      end
    end else if (win_s <= TX_LAST) begin
      tgt_s = T_TX;
      ch_s  = win_s[2:0] - 3'd1;
    end else if (win_s <= RX_LAST) begin
      tgt_s = T_RX;
      ch_s  = win_s[2:0] - 3'd1 - NCH3;
    end else begin
      tgt_s = T_NONE;
    end
  end

  // Register read data and error classification for the setup phase.
  always_comb begin
    rd_data_s = 32'd0;
    err_s     = 1'b0;
    case (tgt_s)
      T_CTRL: begin
        rd_data_s = {1'b1, 7'd0, 8'(rx_overrun_r), 8'(rx_ready_r), 8'(tx_start_r)};
        err_s     = PWRITE & PWDATA[31];
      end
      T_STAT: rd_data_s = {16'd0, 8'(rx_done_st_r), 8'(tx_done_st_r)};
      T_EN:   rd_data_s = {16'd0, 8'(en_rx_r), 8'(en_tx_r)};
      T_ID: begin
        rd_data_s = VERSION;
        err_s     = PWRITE;
      end
      T_TX: err_s = ~PWRITE;
      T_RX: err_s = PWRITE;
      T_NONE: begin
        rd_data_s = 32'hFFFF_FFFF;
        err_s     = 1'b1;
      end
      default: begin
        rd_data_s = 32'hFFFF_FFFF;
        err_s     = 1'b1;
      end
    endcase
    err_eff_s     = err_s & ERR_EN;
    rd_data_eff_s = err_eff_s ? 32'd0 : rd_data_s;
  end

  // Select the addressed channel's RX RAM word.
  always_comb begin
    rx_slice_s = 32'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      rx_slice_s = rx_slice_s | ({32{chan_r == 3'(c)}} & rx_rdata[32*c +: 32]);
    end
  end

  // Register write strobes, taken at the end of the zero-wait access cycle.
  always_comb begin
    commit_s  = (state_r == REG) & PSEL & PENABLE & write_r & ~err_r;
    wr_ctrl_s = commit_s & (tgt_r == T_CTRL);
    wr_stat_s = commit_s & (tgt_r == T_STAT);
    wr_en_s   = commit_s & (tgt_r == T_EN);
  end

  // Transfer FSM with registered APB response and buffer strobes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_r    <= IDLE;
      tgt_r      <= T_NONE;
      chan_r     <= 3'd0;
      wdata_r    <= 32'd0;
      write_r    <= 1'b0;
      err_r      <= 1'b0;
      k_r        <= 2'd0;
      pready_r   <= 1'b0;
      prdata_r   <= 32'd0;
      tx_wen_r   <= {NUM_CH{1'b0}};
      tx_waddr_r <= {(BUF_AW+2){1'b0}};
      tx_wdata_r <= 8'd0;
      rx_ren_r   <= {NUM_CH{1'b0}};
      rx_raddr_r <= {BUF_AW{1'b0}};
    end else begin
      tx_wen_r <= {NUM_CH{1'b0}};
      rx_ren_r <= {NUM_CH{1'b0}};
      pready_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            tgt_r   <= tgt_s;
            chan_r  <= ch_s;
            wdata_r <= PWDATA;
            write_r <= PWRITE;
            err_r   <= err_eff_s;
            if ((tgt_s == T_TX) && PWRITE) begin
              state_r    <= TXB;
              k_r        <= 2'd0;
              prdata_r   <= 32'd0;
              tx_wen_r   <= ch_onehot(ch_s);
              tx_waddr_r <= off_s[BUF_AW+1:0];
              tx_wdata_r <= byte_sel(PWDATA, 2'd0);
            end else if ((tgt_s == T_RX) && !PWRITE) begin
              state_r    <= RXW;
              prdata_r   <= 32'd0;
              rx_ren_r   <= ch_onehot(ch_s);
              rx_raddr_r <= off_s[BUF_AW+1:2];
            end else begin
              state_r  <= REG;
              pready_r <= 1'b1;
              prdata_r <= rd_data_eff_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REG: state_r <= IDLE;
        TXB: begin
          if (!PSEL) begin
            state_r <= IDLE;
          end else if (k_r == 2'd3) begin
            state_r  <= ACK;
            pready_r <= 1'b1;
          end else begin
            k_r        <= k_r + 2'd1;
            tx_wen_r   <= ch_onehot(chan_r);
            tx_waddr_r <= tx_waddr_r + {{(BUF_AW+1){1'b0}}, 1'b1};
            tx_wdata_r <= byte_sel(wdata_r, k_r + 2'd1);
          end
        end
        RXW: begin
          if (!PSEL) begin
            state_r <= IDLE;
          end else begin
            state_r  <= RXD;
            pready_r <= 1'b1;
          end
        end
        RXD: begin
          state_r  <= IDLE;
          prdata_r <= rx_slice_s;
        end
        ACK:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Per-channel flags, sticky status and interrupt enables; hardware set wins.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tx_start_r   <= {NUM_CH{1'b0}};
      rx_ready_r   <= {NUM_CH{1'b0}};
      rx_overrun_r <= {NUM_CH{1'b0}};
      tx_done_st_r <= {NUM_CH{1'b0}};
      rx_done_st_r <= {NUM_CH{1'b0}};
      en_tx_r      <= {NUM_CH{1'b0}};
      en_rx_r      <= {NUM_CH{1'b0}};
    end else begin
      tx_start_r   <= (tx_start_r & ~tx_done)
                    | ({NUM_CH{wr_ctrl_s}} & wdata_r[0 +: NUM_CH]);
      rx_ready_r   <= (rx_ready_r & ~({NUM_CH{wr_ctrl_s}} & wdata_r[8 +: NUM_CH]))
                    | rx_done;
      rx_overrun_r <= (rx_overrun_r & ~({NUM_CH{wr_ctrl_s}} & wdata_r[16 +: NUM_CH]))
                    | (rx_done & rx_ready_r);
      tx_done_st_r <= (tx_done_st_r & ~({NUM_CH{wr_stat_s}} & wdata_r[0 +: NUM_CH]))
                    | tx_done;
      rx_done_st_r <= (rx_done_st_r & ~({NUM_CH{wr_stat_s}} & wdata_r[8 +: NUM_CH]))
                    | rx_done;
      if (wr_en_s) begin
        en_tx_r <= wdata_r[0 +: NUM_CH];
        en_rx_r <= wdata_r[8 +: NUM_CH];
      end else begin
        en_tx_r <= en_tx_r;
        en_rx_r <= en_rx_r;
      end
    end
  end

  // Registered interrupt: lags the status change by one cycle.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= |({rx_done_st_r, tx_done_st_r} & {en_rx_r, en_tx_r});
    end
  end

`ifdef APB_TTC_PSLVERR_EN
  logic pslverr_r;

  // Error response raised with PREADY; errors only take the zero-wait path.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pslverr_r <= 1'b0;
    end else if ((state_r == IDLE) && setup_s) begin
      pslverr_r <= err_s;
    end else begin
      pslverr_r <= 1'b0;
    end
  end

  assign PSLVERR = pslverr_r;
`endif

  // RX data comes straight from the RAM in its single valid cycle.
  assign PRDATA   = (state_r == RXD) ? rx_slice_s : prdata_r;
  assign PREADY   = pready_r;
  assign tx_wen   = tx_wen_r;
  assign tx_waddr = tx_waddr_r;
  assign tx_wdata = tx_wdata_r;
  assign tx_start = tx_start_r;
  assign rx_ren   = rx_ren_r;
  assign rx_raddr = rx_raddr_r;
  assign irq      = irq_r;

endmodule

// File: tb/tb_apb_ttc_buffer_bridge.sv
// Directed self-checking bench for apb_ttc_buffer_bridge (NUM_CH=2, BUF_AW=8).
module tb_apb_ttc_buffer_bridge;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] PADDR = 32'd0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic [1:0]  tx_wen;
  logic [9:0]  tx_waddr;
  logic [7:0]  tx_wdata;
  logic [1:0]  tx_start;
  logic [1:0]  tx_done = 2'b00;
  logic [1:0]  rx_ren;
  logic [7:0]  rx_raddr;
  logic [63:0] rx_rdata = 64'd0;
  logic [1:0]  rx_done = 2'b00;
  logic        irq;
`ifdef APB_TTC_PSLVERR_EN
  logic        PSLVERR;
`endif

  apb_ttc_buffer_bridge #(
    .NUM_CH(2), .BUF_AW(8), .BASE_ADDR(32'h3000_0000), .VERSION(32'h0002_0000)
  ) dut (
    .Clk(Clk), .Rst(Rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .tx_wen(tx_wen), .tx_waddr(tx_waddr), .tx_wdata(tx_wdata),
    .tx_start(tx_start), .tx_done(tx_done), .rx_ren(rx_ren),
    .rx_raddr(rx_raddr), .rx_rdata(rx_rdata), .rx_done(rx_done),
`ifdef APB_TTC_PSLVERR_EN
    .PSLVERR(PSLVERR),
`endif
    .irq(irq)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;

  // RX RAM model: word appears the cycle after rx_ren.
  logic [31:0] rx_mem [0:1][0:255];
  always @(posedge Clk) begin
    for (int c = 0; c < 2; c++) begin
      if (rx_ren[c]) rx_rdata[32*c +: 32] <= rx_mem[c][rx_raddr];
    end
  end

  // Strobe monitor, sampled on the falling edge.
  logic [19:0] tx_log [0:63];
  int          tx_n = 0;
  int          rx_cnt = 0;
  logic [7:0]  rx_seen_addr = 8'd0;
  logic [1:0]  rx_seen_ren = 2'b00;
  always @(negedge Clk) begin
    if (tx_wen != 2'b00 && tx_n < 64) begin
      tx_log[tx_n] <= {tx_wen, tx_waddr, tx_wdata};
      tx_n <= tx_n + 1;
    end
    if (rx_ren != 2'b00) begin
      rx_seen_addr <= rx_raddr;
      rx_seen_ren  <= rx_ren;
      rx_cnt       <= rx_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One APB transfer; optional tx_done/rx_done pulses in the first access cycle.
  task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d,
                     input logic [1:0] txp, input logic [1:0] rxp,
                     output logic [31:0] rd, output int waits, output logic err);
    @(posedge Clk); #1;
    PADDR = a; PWRITE = w; PWDATA = d; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge Clk); #1;
    PENABLE = 1'b1; tx_done = txp; rx_done = rxp; waits = 0;
    while (!PREADY && waits < 16) begin
      @(posedge Clk); #1;
      tx_done = 2'b00; rx_done = 2'b00;
      waits++;
    end
    check("pready_seen", {31'd0, PREADY}, 32'd1);
    rd = PRDATA;
`ifdef APB_TTC_PSLVERR_EN
    err = PSLVERR;
`else
    err = 1'b0;
`endif
    @(posedge Clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; tx_done = 2'b00; rx_done = 2'b00;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; int wt; logic e;
    apb(a, 1'b1, d, 2'b00, 2'b00, rd, wt, e);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; int wt; logic e;
    apb(a, 1'b0, 32'd0, 2'b00, 2'b00, rd, wt, e);
    check(tag, rd, exp);
  endtask

  localparam logic [31:0] B = 32'h3000_0000;
  logic [31:0] rd;
  int          wt;
  logic        er;
  int          base;
  logic [7:0]  d1 [4];
  logic [7:0]  d2 [4];
  logic [9:0]  a2 [4];

  initial begin
    d1 = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    d2 = '{8'h44, 8'h33, 8'h22, 8'h11};
    a2 = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    for (int c = 0; c < 2; c++)
      for (int i = 0; i < 256; i++) rx_mem[c][i] = 32'd0;
    rx_mem[0][5]   = 32'h1234_5678;
    rx_mem[1][255] = 32'hCAFE_F00D;

    repeat (3) @(posedge Clk);
    #1;
    check("rst_outs", {PRDATA[15:0], 3'd0, PREADY, tx_wen, tx_start, rx_ren, irq, tx_wdata[0]}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    Rst = 1'b0;

    // Reset in the middle of a TX byte burst.
    wr(B + 32'h0, 32'h0000_0001);
    check("start_set", {30'd0, tx_start}, 32'd1);
    @(posedge Clk); #1;
    PADDR = B + 32'h2000; PWRITE = 1'b1; PWDATA = 32'h5566_7788; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge Clk); #1;
    PENABLE = 1'b1;
    @(posedge Clk); #1;
    check("mid_txb_wen", {30'd0, tx_wen}, 32'd1);
    Rst = 1'b1;
    #1;
    check("rst_async_outs", {12'd0, PREADY, tx_wen, tx_start, rx_ren, irq, tx_wdata, tx_waddr[0]}, 32'd0);
    check("rst_async_prdata", PRDATA, 32'd0);
    @(posedge Clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    Rst = 1'b0;
    rd_chk("ctrl_after_rst", B + 32'h0, 32'h8000_0000);

    // TX write to channel 1 window + 0x10.
    base = tx_n;
    apb(B + 32'h4010, 1'b1, 32'hA1B2_C3D4, 2'b00, 2'b00, rd, wt, er);
    check("tx1_waits", wt, 32'd4);
    check("tx1_count", tx_n - base, 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("tx1_b%0d", i), {12'd0, tx_log[base+i]},
            {12'd0, 2'b10, 10'h010 + 10'(i), d1[i]});

    // TX byte address wrap on channel 0.
    base = tx_n;
    apb(B + 32'h23FE, 1'b1, 32'h1122_3344, 2'b00, 2'b00, rd, wt, er);
    for (int i = 0; i < 4; i++)
      check($sformatf("wrap_b%0d", i), {12'd0, tx_log[base+i]}, {12'd0, 2'b01, a2[i], d2[i]});

    // TX window read: zero, no wait, no RAM write.
    base = tx_n;
    apb(B + 32'h2000, 1'b0, 32'd0, 2'b00, 2'b00, rd, wt, er);
    check("txrd_data", rd, 32'd0);
    check("txrd_waits", wt, 32'd0);
    check("txrd_nowrite", tx_n - base, 32'd0);
`ifdef APB_TTC_PSLVERR_EN
    check("txrd_err", {31'd0, er}, 32'd1);
`endif

    // RX reads on both channels.
    apb(B + 32'h6014, 1'b0, 32'd0, 2'b00, 2'b00, rd, wt, er);
    check("rx0_data", rd, 32'h1234_5678);
    check("rx0_waits", wt, 32'd1);
    check("rx0_addr", {22'd0, rx_seen_ren, rx_seen_addr}, {22'd0, 2'b01, 8'd5});
    apb(B + 32'h83FC, 1'b0, 32'd0, 2'b00, 2'b00, rd, wt, er);
    check("rx1_data", rd, 32'hCAFE_F00D);
    check("rx1_addr", {22'd0, rx_seen_ren, rx_seen_addr}, {22'd0, 2'b10, 8'hFF});

    // RX window write is ignored.
    base = rx_cnt;
    apb(B + 32'h6000, 1'b1, 32'hDEAD_BEEF, 2'b00, 2'b00, rd, wt, er);
    check("rxwr_waits", wt, 32'd0);
    check("rxwr_noread", rx_cnt - base, 32'd0);

    rd_chk("id", B + 32'hC, 32'h0002_0000);
    wr(B + 32'h8, 32'hFFFF_0101);
    rd_chk("irq_en_rb", B + 32'h8, 32'h0000_0101);

    // tx_done completion and interrupt.
    wr(B + 32'h0, 32'h0000_0001);
    wr(B + 32'h8, 32'h0000_0001);
    check("start_before_done", {30'd0, tx_start}, 32'd1);
    @(posedge Clk); #1; tx_done = 2'b01;
    @(posedge Clk); #1; tx_done = 2'b00;
    check("start_cleared", {30'd0, tx_start}, 32'd0);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(posedge Clk); #1;
    check("irq_rise", {31'd0, irq}, 32'd1);
    rd_chk("stat_txd", B + 32'h4, 32'h0000_0001);
    wr(B + 32'h4, 32'h0000_0001);
    @(posedge Clk); #1;
    check("irq_fall", {31'd0, irq}, 32'd0);
    rd_chk("stat_clr", B + 32'h4, 32'h0000_0000);

    // rx_done twice on channel 1: ready plus overrun.
    @(posedge Clk); #1; rx_done = 2'b10;
    @(posedge Clk); #1; rx_done = 2'b00;
    @(posedge Clk); #1; rx_done = 2'b10;
    @(posedge Clk); #1; rx_done = 2'b00;
    rd_chk("ctrl_ovr", B + 32'h0, 32'h8002_0200);
    rd_chk("stat_rxd", B + 32'h4, 32'h0000_0200);
    check("irq_masked", {31'd0, irq}, 32'd0);
    apb(B + 32'h0, 1'b1, 32'h0000_0200, 2'b00, 2'b10, rd, wt, er);
    rd_chk("ctrl_set_wins", B + 32'h0, 32'h8002_0200);
    wr(B + 32'h0, 32'h0002_0200);
    rd_chk("ctrl_w1c", B + 32'h0, 32'h8000_0000);

    // CPU start and tx_done in the same cycle: start ends at 1.
    apb(B + 32'h0, 1'b1, 32'h0000_0001, 2'b01, 2'b00, rd, wt, er);
    check("start_wins", {30'd0, tx_start}, 32'd1);

    // Unmapped accesses.
    apb(B + 32'h0100, 1'b0, 32'd0, 2'b00, 2'b00, rd, wt, er);
`ifdef APB_TTC_PSLVERR_EN
    check("unmap_rd", rd, 32'd0);
    check("unmap_err", {31'd0, er}, 32'd1);
`else
    check("unmap_rd", rd, 32'hFFFF_FFFF);
`endif
    check("unmap_waits", wt, 32'd0);
`ifndef APB_TTC_PSLVERR_EN
    rd_chk("unmap_hi", B + 32'hA000, 32'hFFFF_FFFF);
`endif
    wr(B + 32'h0104, 32'hFFFF_FFFF);
    rd_chk("unmap_wr_ignored", B + 32'h0, 32'h8000_0001);

    // PSEL drop during a TX burst aborts after the bytes already sent.
    base = tx_n;
    @(posedge Clk); #1;
    PADDR = B + 32'h2020; PWRITE = 1'b1; PWDATA = 32'h0A0B_0C0D; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge Clk); #1;
    PENABLE = 1'b1;
    @(posedge Clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge Clk); #1;
    check("abort_quiet", {30'd0, PREADY, tx_wen[0]}, 32'd0);
    check("abort_bytes", tx_n - base, 32'd2);
    rd_chk("after_abort", B + 32'hC, 32'h0002_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_ttc_buffer_bridge.md
Name: apb_ttc_buffer_bridge

Overview:
- Parametrised APB3 slave linking the MSS CPU to the TTC TX and RX packet buffers of NUM_CH channels.
- Provides a control/status register file with per-channel start, ready and overrun flags.
- Provides a maskable interrupt, TX buffer windows written as four byte-serial RAM writes, and RX buffer windows read with a wait-stated word RAM read.
- Sits between the fabric APB interconnect and the per-channel TX encoder / RX decoder DPSRAMs.

Parameters:
- NUM_CH, 2, channel count, 1..8.
- BUF_AW, 8, buffer word-address width; each window is 4*2^BUF_AW bytes.
- BASE_ADDR, 32'h3000_0000, APB base; low 16 bits must be zero.
- VERSION, 32'h0002_0000, value returned at ID register.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous active-high reset
- PADDR  in  32  APB address
- PSEL  in  1  APB select
- PENABLE  in  1  APB enable
- PWRITE  in  1  APB direction
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data
- PREADY  out  1  APB ready
- tx_wen  out  NUM_CH  per-channel TX byte write strobe
- tx_waddr  out  BUF_AW+2  TX byte address
- tx_wdata  out  8  TX byte data
- tx_start  out  NUM_CH  level; channel has a packet to send
- tx_done  in  NUM_CH  one-cycle pulse; transmission finished
- rx_ren  out  NUM_CH  per-channel RX read strobe
- rx_raddr  out  BUF_AW  RX word address
- rx_rdata  in  32*NUM_CH  RX RAM data, channel c at [32c+31:32c], valid one cycle after rx_ren
- rx_done  in  NUM_CH  one-cycle pulse; packet received
- irq  out  1  level interrupt to CPU

Behaviour:
- Reset is asynchronous and active-high. All outputs are 0 on reset; all flags, IRQ_STAT and IRQ_EN are cleared; the FSM goes to IDLE.
- Address map, offsets from BASE_ADDR:
  - 0x0000 CTRL: bits[NUM_CH-1:0] tx_start, write 1 = set. Bits[8+c] rx_ready, W1C. Bits[16+c] rx_overrun, W1C. Bit31 reads as 1.
  - 0x0004 IRQ_STAT: bit c = tx_done sticky, bit 8+c = rx_done sticky, both W1C.
  - 0x0008 IRQ_EN: read/write.
  - 0x000C ID: read-only, returns VERSION.
  - TX window of channel c at 0x2000*(1+c). RX window of channel c at 0x2000*(1+NUM_CH+c).
- FSM states: IDLE, REG, TXB, RXW, RXD, ACK.
- IDLE: on the setup phase (PSEL=1, PENABLE=0), latch PADDR, PWDATA and PWRITE, decode, then go to REG, TXB or RXW. Unmapped addresses go to REG.
- REG: PREADY=1 in the first access cycle (zero wait states).
  - Reads are muxed into PRDATA.
  - Unmapped read returns 32'hFFFF_FFFF. Unmapped write is ignored.
  - Reserved bits read 0.
- TXB: a 2-bit counter k runs 0..3 on consecutive cycles.
  - Drive tx_wen[c]=1, tx_waddr=addr[BUF_AW+1:0]+k, tx_wdata=PWDATA[8k+7:8k] (little endian).
  - PREADY=1 in the cycle after k=3 (four wait states).
  - A read of a TX window returns 0 with no RAM access.
- RXW: rx_ren[c]=1 and rx_raddr=addr[BUF_AW+1:2] for one cycle.
- RXD: capture the channel c slice into PRDATA and assert PREADY.
  - A write to an RX window is ignored: go to REG path with PREADY only.
- ACK: PREADY is held exactly one cycle. Return to IDLE, then wait for PSEL to drop or a new setup phase.
- An unexpected PSEL drop mid-transfer aborts to IDLE. Any TX bytes already written stay written.
- Flags, per channel c:
  - tx_done pulse clears tx_start[c] and sets IRQ_STAT[c].
  - rx_done sets rx_ready[c] and IRQ_STAT[8+c]. If rx_ready[c] is already 1, it also sets rx_overrun[c].
  - When a hardware set and a CPU clear hit the same cycle, the set wins.
  - When a CPU start and tx_done hit the same cycle, tx_start ends at 1.
- irq is registered: irq = |(IRQ_STAT & IRQ_EN), one cycle after the status change.
- Address wrap: the TX byte address wraps modulo 4*2^BUF_AW.

Optional Feature:
- Macro: APB_TTC_PSLVERR_EN.
- Defined: adds output port PSLVERR (1 bit). PSLVERR is asserted together with PREADY for:
  - unmapped addresses,
  - writes to RX windows, ID or bit31,
  - reads of TX windows.
  
  PRDATA is 0 on error.
- Undefined: no port. Behaviour is exactly as described above.

Test Plan:
- Reset mid TXB transfer: all outputs are 0 immediately, and after release CTRL reads 32'h8000_0000.
- Write 32'hA1B2C3D4 to the channel 1 TX window + 0x10: tx_wen[1] pulses four cycles with addresses 0x10..0x13 and data D4,C3,B2,A1, and PREADY follows after 4 wait cycles.
- Preload RX ch0 word 5 = 32'h12345678, then read BASE+0x2000*(1+NUM_CH)+0x14: rx_raddr=5, PRDATA=32'h12345678, PREADY follows one wait state.
- Write CTRL=1 and IRQ_EN=1, then pulse tx_done[0]: tx_start[0] falls, IRQ_STAT=1, irq rises next cycle. Writing IRQ_STAT=1 drops irq.
- Pulse rx_done[1] twice without a clear: CTRL bits 9 and 17 are set. Writing 1 to bit 9 in the same cycle as a third rx_done leaves bit 9 at 1.
- Read BASE+0x0100: 32'hFFFF_FFFF, and with APB_TTC_PSLVERR_EN, PSLVERR=1 and PRDATA=0.
